// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared frequency-code constants and measurement FSM states
package freq_meter_pkg;

  localparam int FREQ_CODE_W = 8;
  localparam int CODE_MAX    = 49;

  typedef enum logic [1:0] {
    ARM,
    MEAS,
    CALC,
    DONE
  } fm_state_e;

endpackage

// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - sensor pulse in, measured code/status out
interface freq_meter_if
  import freq_meter_pkg::*;
  ();

  logic                   pulse_in;
  logic [FREQ_CODE_W-1:0] code;
  logic                   code_valid;
  logic                   ovr;
  logic                   stall;

  modport master (
    output pulse_in,
    input  code,
    input  code_valid,
    input  ovr,
    input  stall
  );

  modport slave (
    input  pulse_in,
    output code,
    output code_valid,
    output ovr,
    output stall
  );

endinterface

// File: rtl/freq_meter_pulse_sync_edge.sv
// rtl/freq_meter_pulse_sync_edge.sv - 2-FF synchroniser with rising-edge detect
module pulse_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - pulse-period measurement converted to a 1 Hz..50 Hz code
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int CNT_W    = 28,
  parameter int CODE_MAX = freq_meter_pkg::CODE_MAX
) (
  input logic         clk,
  input logic         rst_n,
  freq_meter_if.slave bus
);

  localparam int ACC_W = CNT_W + 1;
  localparam logic [CNT_W-1:0]       CNT_SAT  = CNT_W'(2 * CLK_HZ);
  localparam logic [ACC_W-1:0]       CLK_HZ_A = ACC_W'(CLK_HZ);
  localparam logic [FREQ_CODE_W-1:0] K_MAX    = FREQ_CODE_W'(CODE_MAX + 2);
  localparam logic [FREQ_CODE_W-1:0] K_OVR    = FREQ_CODE_W'(CODE_MAX + 1);
  localparam logic [FREQ_CODE_W-1:0] CODE_TOP = FREQ_CODE_W'(CODE_MAX);

  fm_state_e              r_state;
  fm_state_e              w_state_nxt;
  logic                   w_edge;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_p;
  logic [ACC_W-1:0]       r_acc;
  logic [ACC_W-1:0]       w_acc_sum;
  logic [ACC_W-1:0]       w_thresh;
  logic [FREQ_CODE_W-1:0] r_k;
  logic [FREQ_CODE_W-1:0] r_code;
  logic                   r_code_valid;
  logic                   r_ovr;
  logic                   r_stall;
  logic                   w_calc_done;

  pulse_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.pulse_in),
    .o_edge  (w_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt < CNT_SAT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // k counts how many periods fit below CLK_HZ + P/2, i.e. round(CLK_HZ/P) with ties up
  assign w_acc_sum   = r_acc + {1'b0, r_p};
  assign w_thresh    = CLK_HZ_A + {2'b00, r_p[CNT_W-1:1]};
  assign w_calc_done = (r_k >= K_MAX) || (w_acc_sum > w_thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARM:  if (w_edge) w_state_nxt = MEAS;
      MEAS: begin
        if (w_edge) begin
          w_state_nxt = CALC;
        end else if (r_cnt >= CNT_SAT) begin
          w_state_nxt = ARM;
        end
      end
      CALC: if (w_calc_done) w_state_nxt = DONE;
      DONE: w_state_nxt = MEAS;
      default: w_state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p          <= '0;
      r_acc        <= '0;
      r_k          <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_ovr        <= 1'b0;
      r_stall      <= 1'b1;
    end else begin
      r_code_valid <= 1'b0;
      case (r_state)
        MEAS: begin
          if (w_edge) begin
            r_p   <= r_cnt;
            r_acc <= '0;
            r_k   <= '0;
          end else if (r_cnt >= CNT_SAT) begin
            r_stall <= 1'b1;
          end
        end
        // Results are registered on the last CALC cycle so code_valid lines up with DONE
        CALC: begin
          if (w_calc_done) begin
            r_code_valid <= 1'b1;
            if (r_k == '0) begin
              r_code  <= '0;
              r_ovr   <= 1'b0;
              r_stall <= 1'b1;
            end else if (r_k <= K_OVR) begin
              r_code  <= r_k - FREQ_CODE_W'(1);
              r_ovr   <= 1'b0;
              r_stall <= 1'b0;
            end else begin
              r_code  <= CODE_TOP;
              r_ovr   <= 1'b1;
              r_stall <= 1'b0;
            end
          end else begin
            r_acc <= w_acc_sum;
            r_k   <= r_k + FREQ_CODE_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.ovr        = r_ovr;
  assign bus.stall      = r_stall;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - scoreboard bench for freq_meter at CLK_HZ=1000
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int CLK_HZ = 1000;
  localparam int CNT_W  = 12;
  localparam int KCAP   = CODE_MAX + 2;

  typedef struct {
    int code;
    int ovr;
    int stall;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  freq_meter_if fm_if ();

  freq_meter #(
    .CLK_HZ   (CLK_HZ),
    .CNT_W    (CNT_W),
    .CODE_MAX (CODE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fm_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_valid  = 0;

  int   m_state      = 0;
  int   m_last       = 0;
  int   m_busy_until = 0;
  bit   m_latched    = 0;
  int   t_rise       = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int round_k(input int p);
    return (2 * CLK_HZ + p) / (2 * p);
  endfunction

  // Reference behaviour: edges end a period only while the meter is idle in MEAS
  task automatic model_edge(input int t);
    int   gap;
    int   k;
    exp_t e;
    gap       = t - m_last;
    m_latched = 0;
    if (m_state == 1 && gap > 2 * CLK_HZ) m_state = 0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (t >= m_busy_until) begin
      k = round_k(gap);
      if (k == 0) begin
        e.code = 0; e.ovr = 0; e.stall = 1;
      end else if (k <= CODE_MAX + 1) begin
        e.code = k - 1; e.ovr = 0; e.stall = 0;
      end else begin
        e.code = CODE_MAX; e.ovr = 1; e.stall = 0;
      end
      sb.push_back(e);
      n_pushed++;
      m_busy_until = t + ((k < KCAP) ? k : KCAP) + 3;
      m_latched    = 1;
    end
    m_last = t;
  endtask

  task automatic send(input int p);
    while (cyc < t_rise + p / 2) @(negedge clk);
    fm_if.pulse_in = 1'b0;
    while (cyc < t_rise + p) @(negedge clk);
    fm_if.pulse_in = 1'b1;
    t_rise = cyc;
    model_edge(cyc);
  endtask

  task automatic run(input int p, input int n);
    for (int i = 0; i < n; i++) send(p);
  endtask

  always @(negedge clk) begin
    if (fm_if.code_valid) begin
      exp_t e;
      check_eq("valid_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_valid++;
        check_eq("code", int'(fm_if.code), e.code);
        check_eq("ovr", int'(fm_if.ovr), e.ovr);
        check_eq("stall", int'(fm_if.stall), e.stall);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    fm_if.pulse_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_code", int'(fm_if.code), 0);
    check_eq("rst_valid", int'(fm_if.code_valid), 0);
    check_eq("rst_ovr", int'(fm_if.ovr), 0);
    check_eq("rst_stall", int'(fm_if.stall), 1);
    rst_n = 1'b1;

    repeat (2500) @(negedge clk);
    check_eq("idle_stall", int'(fm_if.stall), 1);
    check_eq("idle_code", int'(fm_if.code), 0);
    t_rise = cyc;

    run(40, 5);
    run(20, 7);
    run(29, 6);
    run(1500, 3);
    run(19, 8);
    run(100, 5);
    repeat (60) @(negedge clk);
    check_eq("drained_1", int'(sb.size()), 0);

    while (cyc < t_rise + 1900) @(negedge clk);
    check_eq("pre_timeout_stall", int'(fm_if.stall), 0);
    check_eq("pre_timeout_code", int'(fm_if.code), 9);
    while (cyc < t_rise + 2010) @(negedge clk);
    check_eq("timeout_stall", int'(fm_if.stall), 1);
    check_eq("timeout_code", int'(fm_if.code), 9);
    check_eq("timeout_ovr", int'(fm_if.ovr), 0);
    send(2100);
    run(100, 3);

    for (int i = 0; i < 10; i++) begin
      send(20);
      if (m_latched) break;
    end
    check_eq("latched_before_reset", int'(m_latched), 1);
    repeat (15) @(negedge clk);
    check_eq("pre_rst_code", int'(fm_if.code), 9);
    check_eq("pre_rst_stall", int'(fm_if.stall), 0);
    rst_n = 1'b0;
    fm_if.pulse_in = 1'b0;
    sb.delete();
    m_state = 0;
    #1;
    check_eq("midcalc_rst_code", int'(fm_if.code), 0);
    check_eq("midcalc_rst_valid", int'(fm_if.code_valid), 0);
    check_eq("midcalc_rst_ovr", int'(fm_if.ovr), 0);
    check_eq("midcalc_rst_stall", int'(fm_if.stall), 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    t_rise = cyc;
    run(20, 6);
    repeat (80) @(negedge clk);
    check_eq("drained_2", int'(sb.size()), 0);
    check_eq("valid_count", n_valid, n_pushed - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
